fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Shares the single write port of the 176x120, 3-bit-per-pixel frame buffer among several drawing FSMs: paddle, ball, and later score or text. Each requester presents single-pixel writes on a valid/ready handshake. The block grants them round-robin, one pixel per cycle, and drives the frame-buffer write port from registers. It also owns the screen-clear sequence: an automatic clear after reset, and an on-demand clear from `clr_req`, which fills the whole buffer with the background colour before any requester is served.

## Interface
Parameters
- `AW`, 15: pixel address width.
- `DW`, 3: pixel data width.
- `NREQ`, 2: number of requesters (2..4).
- `SCREEN_W`, 176: visible width in pixels.
- `SCREEN_H`, 120: visible height in pixels.
- `COLOR_SCREEN`, 3'b101: background colour written during clear.

Ports
- `clk`  in  1  the single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester write request.
- `req_addr`  in  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW].
- `req_data`  in  NREQ*DW  packed pixel data, packed the same way.
- `req_ready`  out  NREQ  one-hot grant, combinational, valid in the current cycle.
- `clr_req`  in  1  single-cycle pulse requesting a full-screen clear.
- `fb_hold`  in  1  stalls all frame-buffer writes while high.
- `clr_busy`  out  1  high while a clear is in progress.
- `mem_px_addr`  out  AW  frame-buffer write address.
- `mem_px_data`  out  DW  frame-buffer write data.
- `px_wr`  out  1  frame-buffer write strobe.
- `err_oob`  out  1  one-cycle pulse when an out-of-range write is accepted and dropped.

## Operation
- Constant: FB_WORDS = SCREEN_W*SCREEN_H = 21120. Address = y*SCREEN_W + x.
- The FSM has two states, CLEAR and ARB.
- Reset: state = CLEAR, clear counter = 0, RR pointer = 0. All outputs are 0, including `mem_px_addr` and `mem_px_data`.
- CLEAR:
  - When `fb_hold` is 0, write `COLOR_SCREEN` to the counter address and increment the counter.
  - After writing address FB_WORDS-1, go to ARB and reset the counter to 0.
  - `req_ready` is all zeros for the whole clear.
  - `clr_busy` is 1 for the whole clear.
- ARB:
  - When `fb_hold` is 0 and any `req_valid` bit is set, grant the first valid requester at or after the RR pointer, searching upward with wrap-around.
  - On a grant, the pointer becomes (granted index + 1) mod NREQ.
  - With no valid requester, the pointer does not change.
- Transfer: happens when `req_valid[i]` and `req_ready[i]` are both high. The requester holds address and data stable until it sees ready.
- Out of range: an accepted address ≥ FB_WORDS is consumed, no write is issued (`px_wr` = 0), and `err_oob` pulses one cycle later.
- `clr_req` in ARB:
  - Go to CLEAR on the next edge. `clr_req` has priority over any grant in the same cycle; no grant is issued that cycle.
- `clr_req` while already in CLEAR: ignored. The counter does not restart.
- `fb_hold` high:
  - Neither grants nor clear writes are issued.
  - `px_wr` = 0, the counter holds, and the pointer holds.
- Reset asserted mid-clear or mid-transfer: aborts immediately. After release, a full clear starts again from address 0.

## Timing
- A transfer in cycle N produces `px_wr` = 1 with the registered address and data in cycle N+1. Latency is 1 cycle.
- Throughput is one pixel per cycle in both states.
- Full clear: FB_WORDS cycles plus hold cycles. `clr_busy` falls in the same cycle the last clear write is presented.
- The first grant is possible in the cycle after `clr_busy` falls.
- `req_ready` depends only on registered state, `req_valid`, `fb_hold` and `clr_req`. There is no path from `req_ready` back into the arbitration logic, so there is no combinational loop.

## Structure
- Shared package `fb_pkg` holds SCREEN_W, SCREEN_H, FB_WORDS, COLOR_SCREEN, COLOR_OBJECT (3'b111) and the paddle and ball geometry constants. The game FSMs use the same package.
- Sub-module `rr_arbiter`:
  - Purely combinational one-hot grant from `req` and `ptr`.
  - Its pointer register sits in the parent block.
- The parent block holds the FSM, the 15-bit clear counter, the output registers and the out-of-range check.

## Test plan
- Reset release, `fb_hold` = 0:
  - 21120 consecutive writes of 3'b101 to addresses 0..21119.
  - `clr_busy` is high throughout and falls in the same cycle as the last write (address 21119).
  - `req_ready` stays 0 throughout.
- Both requesters valid continuously, addresses 100 and 200:
  - Grants alternate 0,1,0,1.
  - `px_wr` shows 100, 200, 100, 200, each one cycle after its grant.
- Only requester 1 valid: granted every cycle. Then requester 0 is raised with the pointer at 0: requester 0 is granted next.
- `fb_hold` pulsed high for 5 cycles mid-clear, at counter 1000:
  - No writes during the hold.
  - Clear resumes at address 1000 with no skipped or duplicated addresses.
- `clr_req` and `req_valid[0]` raised in the same cycle: no grant, CLEAR entered, first clear write to address 0.
- Requester writes address 21120: it is accepted, `px_wr` stays 0, and `err_oob` pulses one cycle later.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer geometry, colours and arbiter state type
package fb_pkg;
   localparam int SCREEN_W = 176;
   localparam int SCREEN_H = 120;
   localparam int FB_WORDS = SCREEN_W * SCREEN_H;
   localparam int FB_AW = 15;
   localparam int FB_DW = 3;
   localparam logic [2:0] COLOR_SCREEN = 3'b101;
   localparam logic [2:0] COLOR_OBJECT = 3'b111;
   localparam int PADDLE_W = 4;
   localparam int PADDLE_H = 24;
   localparam int PADDLE_X = 8;
   localparam int BALL_SIZE = 4;
   typedef enum logic {CLEAR, ARB} fb_state_t;
   function automatic int px_addr(input int x, input int y);
      return y * SCREEN_W + x;
   endfunction
endpackage

// File: rtl/fb_write_arbiter_if.sv
// fb_write_arbiter_if: requester handshake, control and frame-buffer write port
interface fb_write_arbiter_if #(
   parameter int AW = 15,
   parameter int DW = 3,
   parameter int NREQ = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               clr_req;
   logic               fb_hold;
   logic               clr_busy;
   logic [AW-1:0]      mem_px_addr;
   logic [DW-1:0]      mem_px_data;
   logic               px_wr;
   logic               err_oob;
   modport master (
      output req_valid, req_addr, req_data, clr_req, fb_hold,
      input  req_ready, clr_busy, mem_px_addr, mem_px_data, px_wr, err_oob
   );
   modport slave (
      input  req_valid, req_addr, req_data, clr_req, fb_hold,
      output req_ready, clr_busy, mem_px_addr, mem_px_data, px_wr, err_oob
   );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot grant, first request at or above the pointer with wrap
module rr_arbiter #(
   parameter int NREQ = 2,
   localparam int PW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [PW-1:0]   o_idx
);
   logic [PW:0] w_j;
   logic        w_found;
   // scan NREQ slots starting at the pointer, take the first valid one
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      w_found = 1'b0;
      w_j = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_j = {1'b0, i_ptr} + (PW+1)'(k);
         if (w_j >= (PW+1)'(NREQ)) w_j = w_j - (PW+1)'(NREQ);
         if (!w_found && i_req[w_j[PW-1:0]]) begin
            w_found = 1'b1;
            o_gnt[w_j[PW-1:0]] = 1'b1;
            o_idx = w_j[PW-1:0];
         end
      end
   end
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin frame-buffer write sharing with built-in screen clear
module fb_write_arbiter
   import fb_pkg::*;
#(
   parameter int AW = 15,
   parameter int DW = 3,
   parameter int NREQ = 2,
   parameter int SCREEN_W = fb_pkg::SCREEN_W,
   parameter int SCREEN_H = fb_pkg::SCREEN_H,
   parameter logic [DW-1:0] COLOR_SCREEN = fb_pkg::COLOR_SCREEN
) (
   input logic clk,
   input logic rst,
   fb_write_arbiter_if.slave bus
);
   localparam int PW = $clog2(NREQ);
   localparam int NWORDS = SCREEN_W * SCREEN_H;
   localparam logic [AW-1:0] LAST = AW'(NWORDS - 1);
   localparam logic [AW:0] LIMIT = (AW+1)'(NWORDS);
   fb_state_t       r_state, w_state_nxt;
   logic [AW-1:0]   r_cnt, w_cnt_nxt;
   logic [PW-1:0]   r_ptr;
   logic            r_px_wr, r_err_oob, r_clr_busy;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_data;
   logic [NREQ-1:0] w_gnt;
   logic [PW-1:0]   w_idx;
   logic            w_clr_wr, w_xfer, w_oob;
   logic [AW-1:0]   w_addr;
   logic [DW-1:0]   w_data;
   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .i_req(bus.req_valid),
      .i_ptr(r_ptr),
      .o_gnt(w_gnt),
      .o_idx(w_idx)
   );
   assign w_addr = bus.req_addr[int'(w_idx)*AW +: AW];
   assign w_data = bus.req_data[int'(w_idx)*DW +: DW];
   assign w_xfer = |bus.req_ready;
   assign w_oob = {1'b0, w_addr} >= LIMIT;
   // next state, clear stepping and grant gating; clr_req pre-empts any grant
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt = r_cnt;
      w_clr_wr = 1'b0;
      bus.req_ready = '0;
      if (r_state == CLEAR) begin
         if (!bus.fb_hold) begin
            w_clr_wr = 1'b1;
            w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            if (r_cnt == LAST) w_state_nxt = ARB;
         end
      end else if (bus.clr_req) begin
         w_state_nxt = CLEAR;
      end else if (!bus.fb_hold) begin
         bus.req_ready = w_gnt;
      end
   end
   // state, pointer and registered write port; dropped out-of-range writes flag err_oob
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= CLEAR;
         r_cnt <= '0;
         r_ptr <= '0;
         r_px_wr <= 1'b0;
         r_err_oob <= 1'b0;
         r_clr_busy <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt <= w_cnt_nxt;
         r_clr_busy <= (w_state_nxt == CLEAR);
         r_px_wr <= w_clr_wr | (w_xfer & ~w_oob);
         r_err_oob <= w_xfer & w_oob;
         if (w_clr_wr) begin
            r_addr <= r_cnt;
            r_data <= COLOR_SCREEN;
         end else if (w_xfer && !w_oob) begin
            r_addr <= w_addr;
            r_data <= w_data;
         end
         if (w_xfer) r_ptr <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      end
   end
   assign bus.mem_px_addr = r_addr;
   assign bus.mem_px_data = r_data;
   assign bus.px_wr = r_px_wr;
   assign bus.err_oob = r_err_oob;
   assign bus.clr_busy = r_clr_busy;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: lockstep reference-model bench for fb_write_arbiter
module tb_fb_write_arbiter;
   import fb_pkg::*;
   localparam int AW = 15;
   localparam int DW = 3;
   localparam int NREQ = 2;
   localparam int WORDS = 176 * 120;
   logic clk = 1'b0;
   logic rst = 1'b0;
   fb_write_arbiter_if #(.AW(AW), .DW(DW), .NREQ(NREQ)) bus ();
   fb_write_arbiter #(.AW(AW), .DW(DW), .NREQ(NREQ)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );
   always #5 clk = ~clk;
   int  checks = 0;
   int  failures = 0;
   logic val [NREQ];
   int  adr [NREQ];
   int  dat [NREQ];
   logic clr, hold;
   logic m_clr;
   int  m_pos, m_ptr, m_gnt;
   logic e_wr, e_oob, e_busy;
   int  e_addr, e_data;
   // one comparison: count it and report any mismatch
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
      end
   endtask
   task automatic reset_model();
      m_clr = 1'b1;
      m_pos = 0;
      m_ptr = 0;
      e_wr = 1'b0;
      e_oob = 1'b0;
      e_busy = 1'b0;
      e_addr = 0;
      e_data = 0;
   endtask
   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i] = val[i];
         bus.req_addr[i*AW +: AW] = AW'(adr[i]);
         bus.req_data[i*DW +: DW] = DW'(dat[i]);
      end
      bus.clr_req = clr;
      bus.fb_hold = hold;
   endtask
   // drive inputs, compare at the falling edge, advance the model, return just after the rising edge
   task automatic cycle();
      logic [NREQ-1:0] er;
      apply();
      @(negedge clk);
      chk("px_wr", bus.px_wr, e_wr);
      chk("err_oob", bus.err_oob, e_oob);
      chk("clr_busy", bus.clr_busy, e_busy);
      chk("px_addr", bus.mem_px_addr, e_addr);
      chk("px_data", bus.mem_px_data, e_data);
      er = '0;
      m_gnt = -1;
      if (rst && !m_clr && !clr && !hold)
         for (int k = 0; k < NREQ; k++)
            if (m_gnt < 0 && val[(m_ptr + k) % NREQ]) m_gnt = (m_ptr + k) % NREQ;
      if (m_gnt >= 0) er[m_gnt] = 1'b1;
      chk("req_ready", bus.req_ready, er);
      if (rst) begin
         e_wr = 1'b0;
         e_oob = 1'b0;
         if (m_clr) begin
            if (!hold) begin
               e_wr = 1'b1;
               e_addr = m_pos;
               e_data = 5;
               m_pos++;
               if (m_pos == WORDS) begin
                  m_pos = 0;
                  m_clr = 1'b0;
               end
            end
         end else if (clr) begin
            m_clr = 1'b1;
         end else if (m_gnt >= 0) begin
            m_ptr = (m_gnt + 1) % NREQ;
            if (adr[m_gnt] < WORDS) begin
               e_wr = 1'b1;
               e_addr = adr[m_gnt];
               e_data = dat[m_gnt];
            end else begin
               e_oob = 1'b1;
            end
         end
         e_busy = m_clr;
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      for (int i = 0; i < NREQ; i++) begin
         val[i] = 1'b0;
         adr[i] = 0;
         dat[i] = 0;
      end
      clr = 1'b0;
      hold = 1'b0;
      reset_model();
      repeat (3) cycle();
      rst = 1'b1;
      repeat (WORDS + 2) cycle();
      val[0] = 1'b1; adr[0] = 100; dat[0] = 3;
      val[1] = 1'b1; adr[1] = 200; dat[1] = 6;
      repeat (6) cycle();
      val[0] = 1'b0;
      repeat (4) cycle();
      val[0] = 1'b1;
      repeat (2) cycle();
      val[0] = 1'b0; val[1] = 1'b0;
      val[0] = 1'b1; adr[0] = WORDS; dat[0] = 7;
      cycle();
      val[0] = 1'b0;
      repeat (2) cycle();
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NREQ; i++)
            if (!val[i] && $urandom_range(0, 2) == 0) begin
               val[i] = 1'b1;
               adr[i] = ($urandom_range(0, 9) == 0) ? WORDS + int'($urandom_range(0, 100))
                                                    : int'($urandom_range(0, WORDS - 1));
               dat[i] = int'($urandom_range(0, 7));
            end
         hold = ($urandom_range(0, 5) == 0);
         cycle();
         if (m_gnt >= 0) val[m_gnt] = 1'b0;
      end
      hold = 1'b0;
      val[1] = 1'b0;
      val[0] = 1'b1; adr[0] = 50; dat[0] = 2;
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      val[0] = 1'b0;
      clr = 1'b1;
      repeat (3) cycle();
      clr = 1'b0;
      repeat (997) cycle();
      hold = 1'b1;
      repeat (5) cycle();
      hold = 1'b0;
      repeat (WORDS - 1000 + 2) cycle();
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      repeat (300) cycle();
      rst = 1'b0;
      reset_model();
      repeat (2) cycle();
      rst = 1'b1;
      repeat (50) cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
